// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: FIFO handshake/status bundle; error flag signals present only with SYNC_FIFO_ERR_EN
interface sync_fifo_param_if #(parameter int DATA_W = 6, parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);
  logic ena;
  logic wr_en;
  logic [DATA_W-1:0] wr_data;
  logic rd_en;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [AW:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic overflow;
  logic underflow;
  logic err_clr;
  modport master (
    output ena, wr_en, wr_data, rd_en, err_clr,
    input rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input ena, wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
`else
  modport master (
    output ena, wr_en, wr_data, rd_en,
    input rd_data, rd_valid, full, empty, almost_full, almost_empty, count
  );
  modport slave (
    input ena, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count
  );
`endif
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised sync FIFO with count, almost flags, registered read; sticky errors with SYNC_FIFO_ERR_EN
module sync_fifo_param #(
  parameter int DATA_W = 6,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic rst,
  sync_fifo_param_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_THRESH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [DATA_W-1:0] rd_q;
  logic vld_q, full, empty, rd_acc, wr_acc;
  assign full = cnt == FULL_C;
  assign empty = cnt == '0;
  assign rd_acc = f.ena & f.rd_en & ~empty;
  assign wr_acc = f.ena & f.wr_en & (~full | rd_acc);
  assign f.full = full;
  assign f.empty = empty;
  assign f.almost_full = cnt >= AF_C;
  assign f.almost_empty = cnt <= AE_C;
  assign f.count = cnt;
  assign f.rd_data = rd_q;
  assign f.rd_valid = vld_q;
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= f.wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      rd_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_q <= mem[rd_ptr];
      end
      cnt <= cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
    end
`ifdef SYNC_FIFO_ERR_EN
  logic ovf, unf;
  assign f.overflow = ovf;
  assign f.underflow = unf;
  always_ff @(posedge clk)
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (f.ena & f.wr_en & full & ~rd_acc) | (ovf & ~(f.ena & f.err_clr));
      unf <= (f.ena & f.rd_en & empty) | (unf & ~(f.ena & f.err_clr));
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed plus random checks of sync_fifo_param against a queue model
module tb_sync_fifo_param;
  localparam int DEPTH = 16;
  localparam int AF = DEPTH - 2;
  localparam int AE = 2;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int passed = 0;
  logic [5:0] q[$];
  logic [5:0] exp_data = '0;
  bit exp_valid = 0;
`ifdef SYNC_FIFO_ERR_EN
  bit ovf = 0, unf = 0;
`endif
  sync_fifo_param_if #(.DATA_W(6), .DEPTH(DEPTH)) f ();
  sync_fifo_param #(.DATA_W(6), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .f(f));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle(input bit r, input bit e, input bit we, input logic [5:0] wd, input bit re);
    bit ra, wa;
    rst = r;
    f.ena = e;
    f.wr_en = we;
    f.wr_data = wd;
    f.rd_en = re;
    ra = e && re && q.size() > 0;
    wa = e && we && (q.size() < DEPTH || ra);
    if (r) begin
      q.delete();
      exp_data = '0;
      exp_valid = 0;
`ifdef SYNC_FIFO_ERR_EN
      ovf = 0;
      unf = 0;
`endif
    end else begin
`ifdef SYNC_FIFO_ERR_EN
      ovf = (e && we && q.size() == DEPTH && !ra) || (ovf && !(e && f.err_clr));
      unf = (e && re && q.size() == 0) || (unf && !(e && f.err_clr));
`endif
      exp_valid = ra;
      if (ra) exp_data = q.pop_front();
      if (wa) q.push_back(wd);
    end
    @(posedge clk);
    #1;
    check("rd_valid", 32'(f.rd_valid), 32'(exp_valid));
    check("rd_data", 32'(f.rd_data), 32'(exp_data));
    check("count", 32'(f.count), 32'(q.size()));
    check("full", 32'(f.full), 32'(q.size() == DEPTH));
    check("empty", 32'(f.empty), 32'(q.size() == 0));
    check("almost_full", 32'(f.almost_full), 32'(q.size() >= AF));
    check("almost_empty", 32'(f.almost_empty), 32'(q.size() <= AE));
`ifdef SYNC_FIFO_ERR_EN
    check("overflow", 32'(f.overflow), 32'(ovf));
    check("underflow", 32'(f.underflow), 32'(unf));
`endif
  endtask

  initial begin
`ifdef SYNC_FIFO_ERR_EN
    f.err_clr = 1'b0;
`endif
    cycle(1, 1, 0, 0, 0);
    check("reset_empty", 32'(f.empty), 32'd1);
    check("reset_count", 32'(f.count), 32'd0);
    for (int i = 1; i <= 16; i++) cycle(0, 1, 1, 6'(i), 0);
    check("filled_count", 32'(f.count), 32'd16);
    check("filled_full", 32'(f.full), 32'd1);
    cycle(0, 1, 1, 6'h3F, 0);
    check("write_when_full_ignored", 32'(f.count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 0, 0, 1);
      check("drain_order", 32'(f.rd_data), 32'(i));
    end
    check("drained_empty", 32'(f.empty), 32'd1);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    check("hold_after_empty", 32'(f.rd_data), 32'h10);
    for (int i = 1; i <= 16; i++) cycle(0, 1, 1, 6'(i), 0);
    cycle(0, 1, 1, 6'h2A, 1);
    check("full_rw_data", 32'(f.rd_data), 32'h01);
    check("full_rw_count", 32'(f.count), 32'd16);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 1);
    check("full_rw_last", 32'(f.rd_data), 32'h2A);
    cycle(0, 1, 1, 6'h15, 1);
    check("empty_rw_novalid", 32'(f.rd_valid), 32'd0);
    check("empty_rw_count", 32'(f.count), 32'd1);
    cycle(0, 1, 0, 0, 1);
    check("empty_rw_read", 32'(f.rd_data), 32'h15);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 6'(i + 7), 0);
    cycle(1, 1, 1, 6'h33, 0);
    check("midreset_count", 32'(f.count), 32'd0);
    check("midreset_valid", 32'(f.rd_valid), 32'd0);
    cycle(0, 1, 1, 6'h11, 0);
    cycle(0, 1, 1, 6'h22, 0);
    cycle(0, 0, 1, 6'h3C, 1);
    cycle(0, 0, 1, 6'h3D, 1);
    check("ena_low_count", 32'(f.count), 32'd2);
    cycle(0, 1, 0, 0, 1);
    check("ena_low_first", 32'(f.rd_data), 32'h11);
`ifdef SYNC_FIFO_ERR_EN
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    check("underflow_set", 32'(f.underflow), 32'd1);
    for (int i = 0; i < 17; i++) cycle(0, 1, 1, 6'(i), 0);
    cycle(0, 1, 0, 0, 0);
    check("overflow_sticky", 32'(f.overflow), 32'd1);
    f.err_clr = 1'b1;
    cycle(0, 1, 0, 0, 0);
    f.err_clr = 1'b0;
    check("err_clr_ovf", 32'(f.overflow), 32'd0);
    check("err_clr_unf", 32'(f.underflow), 32'd0);
`endif
    for (int i = 0; i < 800; i++) begin
      bit wbias;
      wbias = ((i / 60) % 2) == 0;
`ifdef SYNC_FIFO_ERR_EN
      f.err_clr = ($urandom % 16) == 0;
`endif
      cycle(($urandom % 97) == 0, ($urandom % 8) != 0,
            wbias ? ($urandom % 4) != 0 : ($urandom % 4) == 0,
            6'($urandom),
            wbias ? ($urandom % 4) == 0 : ($urandom % 4) != 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
